// File: rtl/seq_gen_1001_1110_pkg.sv
// Shared constants for the 1001/1110 pattern transmitter: fixed words, select codes, FSM states.
// Pure declarations, no logic, no latency.
// No flow control of its own; users follow the valid/ready rules of the transmitter.
package seq_pkg;

  localparam logic [3:0] PAT_1001 = 4'b1001;
  localparam logic [3:0] PAT_1110 = 4'b1110;

  localparam logic [1:0] SEL_1001 = 2'b00;
  localparam logic [1:0] SEL_1110 = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;
  localparam logic [1:0] SEL_INV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_gen_1001_1110_if.sv
// Request/serial-output bundle between a requester and the pattern transmitter.
// Wires only, zero latency.
// Request side is valid/ready; the serial side has no backpressure.
interface seq_gen_1001_1110_if #(
  parameter int WORD_W = 4,
  parameter int CNT_W  = 4,
  parameter int GAP_W  = 3
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic [WORD_W-1:0] req_word;
  logic [CNT_W-1:0]  req_rep;
  logic [GAP_W-1:0]  req_gap;
  logic              sout;
  logic              sout_valid;
  logic              busy;
  logic              done;

  modport master (
    output req_valid, req_sel, req_word, req_rep, req_gap,
    input  req_ready, sout, sout_valid, busy, done
  );

  modport slave (
    input  req_valid, req_sel, req_word, req_rep, req_gap,
    output req_ready, sout, sout_valid, busy, done
  );

endinterface

// File: rtl/seq_gen_1001_1110_piso.sv
// Parallel-in serial-out shifter, MSB first, zero fill from the LSB end.
// Load or shift takes effect on the next clock; msb is a direct flop output.
// No backpressure: load wins over shift, idle holds the contents.
module piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= din;
    end else if (shift) begin
      shreg_q <= {shreg_q[W-2:0], 1'b0};
    end
  end

  assign msb = shreg_q[W-1];

endmodule

// File: rtl/seq_gen_1001_1110.sv
// Serial pattern transmitter: each accepted request becomes (rep+1) MSB-first words with idle gaps.
// First bit valid the cycle after accept; accept->done = WORD_W*(rep+1) + gap*rep cycles.
// req_ready only in IDLE; requests offered while busy are dropped, serial side never stalls.
module seq_gen_1001_1110
  import seq_pkg::*;
#(
  parameter int WORD_W = 4,
  parameter int CNT_W  = 4,
  parameter int GAP_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_gen_1001_1110_if.slave   bus
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [GAP_W-1:0]  gap;
  } job_t;

  state_e            state_q, state_nxt;
  logic [BIT_W-1:0]  bit_q, bit_nxt;
  logic [CNT_W-1:0]  rep_q, rep_nxt;
  logic [GAP_W-1:0]  gap_q, gap_nxt;
  job_t              job_q, job_nxt;

  logic              rdy_q;
  logic              busy_q;
  logic              vld_q;
  logic              done_q, done_nxt;

  logic              ld;
  logic              sh;
  logic [WORD_W-1:0] ld_val;
  logic [WORD_W-1:0] sel_word;
  logic              shreg_msb;

  always_comb begin
    sel_word = bus.req_word;
    case (bus.req_sel)
      SEL_1001: sel_word = WORD_W'(PAT_1001);
      SEL_1110: sel_word = WORD_W'(PAT_1110);
      SEL_WORD: sel_word = bus.req_word;
      SEL_INV:  sel_word = ~bus.req_word;
      default:  sel_word = bus.req_word;
    endcase
  end

  // Entering GAP loads zeros so sout reads 0 there without an output gate;
  // the final shift of a job likewise drains the register to zero.
  always_comb begin
    state_nxt = state_q;
    bit_nxt   = bit_q;
    rep_nxt   = rep_q;
    gap_nxt   = gap_q;
    job_nxt   = job_q;
    ld        = 1'b0;
    sh        = 1'b0;
    ld_val    = job_q.word;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          job_nxt.word = sel_word;
          job_nxt.gap  = bus.req_gap;
          ld           = 1'b1;
          ld_val       = sel_word;
          bit_nxt      = LAST_BIT;
          rep_nxt      = bus.req_rep;
          state_nxt    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (bit_q != '0) begin
          sh      = 1'b1;
          bit_nxt = bit_q - BIT_W'(1);
        end else if (rep_q == '0) begin
          sh        = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          rep_nxt = rep_q - CNT_W'(1);
          bit_nxt = LAST_BIT;
          ld      = 1'b1;
          if (job_q.gap == '0) begin
            ld_val = job_q.word;
          end else begin
            ld_val    = '0;
            gap_nxt   = job_q.gap - GAP_W'(1);
            state_nxt = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          ld        = 1'b1;
          ld_val    = job_q.word;
          state_nxt = ST_SHIFT;
        end else begin
          gap_nxt = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    done_nxt = (state_nxt == ST_SHIFT) && (bit_nxt == '0) && (rep_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      job_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      bit_q   <= bit_nxt;
      rep_q   <= rep_nxt;
      gap_q   <= gap_nxt;
      job_q   <= job_nxt;
      rdy_q   <= (state_nxt == ST_IDLE);
      busy_q  <= (state_nxt != ST_IDLE);
      vld_q   <= (state_nxt == ST_SHIFT);
      done_q  <= done_nxt;
    end
  end

  piso_shift #(
    .W (WORD_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (ld),
    .shift (sh),
    .din   (ld_val),
    .msb   (shreg_msb)
  );

  assign bus.req_ready  = rdy_q;
  assign bus.busy       = busy_q;
  assign bus.sout_valid = vld_q;
  assign bus.sout       = shreg_msb;
  assign bus.done       = done_q;

  a_sout_gated: assert property (@(posedge clk) disable iff (rst) (!vld_q |-> !shreg_msb));
  a_done_valid: assert property (@(posedge clk) disable iff (rst) (done_q |-> vld_q));
  a_rdy_busy:   assert property (@(posedge clk) disable iff (rst) (rdy_q != busy_q));

endmodule

// File: tb/tb_seq_gen_1001_1110.sv
// Bench for seq_gen_1001_1110: directed table, reset abort, held-valid back-to-back, random jobs.
module tb_seq_gen_1001_1110;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_gen_1001_1110_if #(.WORD_W(4), .CNT_W(4), .GAP_W(3)) dif ();

  seq_gen_1001_1110 #(.WORD_W(4), .CNT_W(4), .GAP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] sel;
    logic [3:0] word;
    logic [3:0] rep;
    logic [2:0] gap;
    logic [3:0] exp_word;
    int         exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // {req_ready, busy, sout_valid, sout, done}
  function automatic logic [4:0] obs();
    return {dif.req_ready, dif.busy, dif.sout_valid, dif.sout, dif.done};
  endfunction

  function automatic logic [3:0] spec_word(input logic [1:0] sel, input logic [3:0] word);
    case (sel)
      2'b00:   return 4'b1001;
      2'b01:   return 4'b1110;
      2'b10:   return word;
      default: return ~word;
    endcase
  endfunction

  task automatic junk();
    dif.req_sel  = 2'($urandom_range(0, 3));
    dif.req_word = 4'($urandom_range(0, 15));
    dif.req_rep  = 4'($urandom_range(0, 15));
    dif.req_gap  = 3'($urandom_range(0, 7));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
  task automatic play(input logic [1:0] sel, input logic [3:0] word, input logic [3:0] rep,
                      input logic [2:0] gap, input logic [3:0] exp_word, input bit hold,
                      input string tag, output int done_at);
    logic [4:0] q[$];
    int waited;
    logic [4:0] o;
    for (int w = 0; w <= int'(rep); w++) begin
      for (int b = 3; b >= 0; b--)
        q.push_back({1'b0, 1'b1, 1'b1, exp_word[b], (w == int'(rep)) && (b == 0)});
      if (w < int'(rep))
        for (int g = 0; g < int'(gap); g++) q.push_back(5'b01000);
    end
    waited = 0;
    while (dif.req_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_rdy"}, {31'd0, dif.req_ready}, 32'd1);
    dif.req_valid = 1'b1;
    dif.req_sel   = sel;
    dif.req_word  = word;
    dif.req_rep   = rep;
    dif.req_gap   = gap;
    @(negedge clk);
    dif.req_valid = hold;
    junk();
    done_at = -1;
    foreach (q[i]) begin
      o = obs();
      chk($sformatf("%s_c%0d", tag, i), {27'd0, o}, {27'd0, q[i]});
      if (o[0] === 1'b1 && done_at < 0) done_at = i + 1;
      @(negedge clk);
      junk();
    end
    chk({tag, "_idle"}, {27'd0, obs()}, {27'd0, 5'b10000});
  endtask

  vec_t tbl[7];
  int   d;
  bit   hold;
  logic [1:0] rs;
  logic [3:0] rw, rr;
  logic [2:0] rg;

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{2'b00, 4'h0,    4'd0,  3'd0, 4'b1001, 4};
    tbl[1] = '{2'b01, 4'h5,    4'd2,  3'd0, 4'b1110, 12};
    tbl[2] = '{2'b10, 4'b1011, 4'd1,  3'd3, 4'b1011, 11};
    tbl[3] = '{2'b11, 4'b0110, 4'd0,  3'd0, 4'b1001, 4};
    tbl[4] = '{2'b10, 4'b0000, 4'd0,  3'd0, 4'b0000, 4};
    tbl[5] = '{2'b00, 4'h0,    4'd15, 3'd0, 4'b1001, 64};
    tbl[6] = '{2'b01, 4'h0,    4'd0,  3'd7, 4'b1110, 4};

    dif.req_valid = 1'b0;
    dif.req_sel   = 2'b00;
    dif.req_word  = 4'h0;
    dif.req_rep   = 4'h0;
    dif.req_gap   = 3'h0;
    rst = 1'b1;
    @(negedge clk);
    chk("reset", {27'd0, obs()}, {27'd0, 5'b10000});
    dif.req_valid = 1'b1;
    @(negedge clk);
    chk("reset_vld_ignored", {27'd0, obs()}, {27'd0, 5'b10000});
    dif.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset", {27'd0, obs()}, {27'd0, 5'b10000});

    for (int i = 0; i < 7; i++) begin
      play(tbl[i].sel, tbl[i].word, tbl[i].rep, tbl[i].gap, tbl[i].exp_word, 1'b0,
           $sformatf("tbl%0d", i), d);
      chk($sformatf("tbl%0d_lat", i), d, tbl[i].exp_cycles);
    end

    // reset during the second bit of a repeating 1110 job
    dif.req_valid = 1'b1;
    dif.req_sel   = 2'b01;
    dif.req_rep   = 4'd3;
    dif.req_gap   = 3'd0;
    @(negedge clk);
    dif.req_valid = 1'b0;
    chk("abort_b1", {27'd0, obs()}, {27'd0, 5'b01110});
    @(negedge clk);
    chk("abort_b2", {27'd0, obs()}, {27'd0, 5'b01110});
    rst = 1'b1;
    dif.req_valid = 1'b1;
    @(negedge clk);
    chk("abort_rst", {27'd0, obs()}, {27'd0, 5'b10000});
    rst = 1'b0;
    play(2'b00, 4'h0, 4'd0, 3'd0, 4'b1001, 1'b0, "post_abort", d);
    chk("post_abort_lat", d, 4);

    // valid held high across two jobs, second one at maximum rep and gap
    play(2'b10, 4'b1100, 4'd1, 3'd2, 4'b1100, 1'b1, "hold_a", d);
    chk("hold_a_lat", d, 10);
    play(2'b11, 4'b0001, 4'd15, 3'd7, 4'b1110, 1'b1, "hold_b", d);
    chk("hold_b_lat", d, 64 + 7 * 15);
    dif.req_valid = 1'b0;
    @(negedge clk);
    chk("hold_end", {27'd0, obs()}, {27'd0, 5'b10000});

    hold = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      rs   = 2'($urandom_range(0, 3));
      rw   = 4'($urandom_range(0, 15));
      rr   = 4'($urandom_range(0, 15));
      rg   = 3'($urandom_range(0, 7));
      hold = 1'($urandom_range(0, 1));
      play(rs, rw, rr, rg, spec_word(rs, rw), hold, $sformatf("rnd%0d", k), d);
      chk($sformatf("rnd%0d_lat", k), d, 4 * (int'(rr) + 1) + int'(rg) * int'(rr));
    end
    dif.req_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
